inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 13 +
 rtl/inst_fetch_if.sv | 26 ++
 rtl/inst_fetch_buffer.sv | 54 +++++
 rtl/inst_fetch.sv | 84 ++++++++
 tb/tb_inst_fetch.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {BOOT, RUN} fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// ROM, redirect and decode-side signals of the fetch stage.
interface inst_fetch_if;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign;

    modport master (
        output rom_addr, out_valid, out_inst, out_pc, out_pc_plus4, misalign,
        input  rom_data, redirect_valid, redirect_target, stall, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_inst, out_pc, out_pc_plus4, misalign,
        output rom_data, redirect_valid, redirect_target, stall, out_ready
    );

endinterface

// File: rtl/inst_fetch_buffer.sv
// Circular fetch output buffer; the caller guarantees no push when full without pop.
module fetch_buffer
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_entry,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, BOOT/RUN control and redirect handling around fetch_buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic       clock,
    input  logic       reset,
    inst_fetch_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            fetch_en;
    logic            valid;
    logic            pop;
    logic [CntW-1:0] count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign valid = (count != '0);
    assign pop   = valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        fetch_en   = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     fetch_en = !bus.stall && !bus.redirect_valid && ((count < FullCount) || pop);
            default: state_d = BOOT;
        endcase
        // Redirect wins over everything and also works during BOOT.
        if (bus.redirect_valid) begin
            pc_d = {bus.redirect_target[31:2], 2'b00};
            if (bus.redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (fetch_en) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign push_entry = '{pc: pc_q, inst: bus.rom_data};

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (fetch_en),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (count)
    );

    assign bus.rom_addr     = pc_q;
    assign bus.out_valid    = valid;
    assign bus.out_inst     = head_entry.inst;
    assign bus.out_pc       = head_entry.pc;
    assign bus.out_pc_plus4 = head_entry.pc + 32'd4;
    assign bus.misalign     = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with DEPTH = 2 and a ROM returning word[i] = i.
module tb_inst_fetch;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    inst_fetch_if bus ();

    // ROM model: word at byte address a is a >> 2.
    assign bus.rom_data = {2'b00, bus.rom_addr[31:2]};

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.out_ready       = 1'b1;
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;

        // Reset state
        cycles(2);
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_addr", bus.rom_addr, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'd0);

        // BOOT cycle: no fetch
        reset = 1'b0;
        cycles(1);
        check("boot_valid", {31'b0, bus.out_valid}, 32'd0);
        check("boot_addr", bus.rom_addr, 32'h0);

        // Streaming, one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            check("stream_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stream_pc", bus.out_pc, 32'(i * 4));
            check("stream_inst", bus.out_inst, 32'(i));
            check("stream_pc4", bus.out_pc_plus4, 32'(i * 4 + 4));
        end

        // Backpressure: head 12, buffer fills to DEPTH
        bus.out_ready = 1'b0;
        cycles(5);
        check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp_head", bus.out_pc, 32'd12);
        check("bp_addr", bus.rom_addr, 32'd20);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("bp_resume_pc", bus.out_pc, 32'(16 + i * 4));
            check("bp_resume_inst", bus.out_inst, 32'(4 + i));
        end

        // Redirect to 0x40 with full buffer (24, 28 held)
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        cycles(1);
        check("redir_valid", {31'b0, bus.out_valid}, 32'd0);
        check("redir_addr", bus.rom_addr, 32'h40);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        cycles(1);
        check("redir_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("redir_out_pc", bus.out_pc, 32'h40);
        check("redir_out_inst", bus.out_inst, 32'd16);

        // Misaligned redirect
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h22;
        cycles(1);
        check("mis_flag", {31'b0, bus.misalign}, 32'd1);
        check("mis_valid", {31'b0, bus.out_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        cycles(1);
        check("mis_pc", bus.out_pc, 32'h20);
        check("mis_inst", bus.out_inst, 32'd8);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        cycles(1);
        check("mis_sticky", {31'b0, bus.misalign}, 32'd1);
        bus.redirect_valid = 1'b0;
        cycles(1);
        check("aligned_pc", bus.out_pc, 32'h100);
        check("aligned_inst", bus.out_inst, 32'h40);

        // Stall: drain 0x100, PC frozen at 0x104
        bus.stall = 1'b1;
        cycles(1);
        check("stall_drain", {31'b0, bus.out_valid}, 32'd0);
        check("stall_addr0", bus.rom_addr, 32'h104);
        cycles(2);
        check("stall_valid", {31'b0, bus.out_valid}, 32'd0);
        check("stall_addr2", bus.rom_addr, 32'h104);
        bus.stall = 1'b0;
        cycles(1);
        check("stall_resume_pc", bus.out_pc, 32'h104);
        check("stall_resume_inst", bus.out_inst, 32'h41);

        // PC wrap at top of address space
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        cycles(1);
        bus.redirect_valid = 1'b0;
        cycles(1);
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", bus.out_pc_plus4, 32'h0);
        check("wrap_inst", bus.out_inst, 32'h3FFF_FFFF);
        check("wrap_addr", bus.rom_addr, 32'h0);
        cycles(1);
        check("wrap_next_pc", bus.out_pc, 32'h0);

        // Reset mid-stream with a concurrent redirect
        reset               = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h80;
        cycles(1);
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_addr", bus.rom_addr, 32'h0);
        check("mid_rst_misalign", {31'b0, bus.misalign}, 32'd0);
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        cycles(1);
        check("mid_boot_valid", {31'b0, bus.out_valid}, 32'd0);
        cycles(1);
        check("mid_restart_pc", bus.out_pc, 32'h0);
        check("mid_restart_valid", {31'b0, bus.out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
